// File: rtl/fofb_dsp_readout_sequencer_if.sv
// AXI-Stream bundle carrying gathered BPM readouts to the FOFB correction DSP.
interface fofb_dsp_readout_sequencer_if #(
  parameter int INDEX_WIDTH = 9
);
  logic                 TVALID;
  logic                 TREADY;
  logic [95:0]          TDATA;
  logic [INDEX_WIDTH:0] TUSER;
  logic                 TLAST;

  modport master (output TVALID, TDATA, TUSER, TLAST, input TREADY);
  modport slave  (input TVALID, TDATA, TUSER, TLAST, output TREADY);
endinterface

// File: rtl/fofb_dsp_readout_sequencer.sv
// Per-FA-frame sweep of the gather-stage readout address, streaming merged
// X/Y/S per BPM slot through a 2-entry skid FIFO onto AXI-Stream.
module fofb_dsp_readout_sequencer #(
  parameter int FOFB_INDEX_WIDTH = 9,
  parameter int BPM_COUNT_WIDTH  = FOFB_INDEX_WIDTH + 1,
  parameter int STAT_WIDTH       = 16
) (
  input  logic                        sysClk,
  input  logic                        sysResetN,
  input  logic                        FAstrobe,
  input  logic                        readoutValid,
  input  logic                        sysTimeoutStrobe,
  input  logic                        fofbEnabled,
  input  logic [BPM_COUNT_WIDTH-1:0]  bpmCount,
  output logic [FOFB_INDEX_WIDTH-1:0] fofbDSPreadoutAddress,
  input  logic [31:0]                 fofbDSPreadoutX,
  input  logic [31:0]                 fofbDSPreadoutY,
  input  logic [31:0]                 fofbDSPreadoutS,
  fofb_dsp_readout_sequencer_if.master M_AXIS,
  output logic                        busy,
  output logic [STAT_WIDTH-1:0]       sweepCount,
  output logic [STAT_WIDTH-1:0]       timeoutCount,
  output logic [STAT_WIDTH-1:0]       overrunCount
);

  typedef enum logic [1:0] {IDLE, WAIT_VALID, SWEEP, PARK} state_t;

  state_t                      state, stateNext;
  logic [BPM_COUNT_WIDTH-1:0]  nReg, nextIdx;
  logic                        enTag;
  logic                        flightValid, flightLast;
  logic [FOFB_INDEX_WIDTH-1:0] flightIdx;
  logic [95:0]                 fifoData [2];
  logic [FOFB_INDEX_WIDTH-1:0] fifoIdx  [2];
  logic                        fifoLast [2];
  logic                        wrPtr, rdPtr;
  logic [1:0]                  fifoCount, occAfterPop;
  logic                        pop, issue, issueLast, sweepDone;

  function automatic logic [STAT_WIDTH-1:0] satInc(input logic [STAT_WIDTH-1:0] v);
    return (v == '1) ? v : v + STAT_WIDTH'(1);
  endfunction

  assign M_AXIS.TVALID = (fifoCount != 2'd0);
  assign M_AXIS.TDATA  = fifoData[rdPtr];
  assign M_AXIS.TUSER  = {enTag, fifoIdx[rdPtr]};
  assign M_AXIS.TLAST  = fifoLast[rdPtr];
  assign busy          = (state != IDLE);

  always_comb begin
    pop         = M_AXIS.TVALID && M_AXIS.TREADY;
    // Credit the beat leaving this cycle so one issue per cycle sustains full rate
    occAfterPop = fifoCount - 2'(pop);
    issue       = (state == SWEEP) && ((occAfterPop + 2'(flightValid)) < 2'd2);
    issueLast   = (nextIdx == nReg - BPM_COUNT_WIDTH'(1));
    sweepDone   = (state == PARK) && pop && fifoLast[rdPtr];
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:       if (FAstrobe && bpmCount != '0) stateNext = WAIT_VALID;
      WAIT_VALID: if (readoutValid)               stateNext = SWEEP;
                  else if (sysTimeoutStrobe)      stateNext = IDLE;
      SWEEP:      if (issue && issueLast)         stateNext = PARK;
      PARK:       if (sweepDone)                  stateNext = IDLE;
      default:                                    stateNext = IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) state <= IDLE;
    else            state <= stateNext;
  end

  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) begin
      nReg                  <= '0;
      nextIdx               <= '0;
      enTag                 <= 1'b0;
      fofbDSPreadoutAddress <= '0;
      flightValid           <= 1'b0;
      flightIdx             <= '0;
      flightLast            <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifoData[i] <= '0;
        fifoIdx[i]  <= '0;
        fifoLast[i] <= 1'b0;
      end
      wrPtr        <= 1'b0;
      rdPtr        <= 1'b0;
      fifoCount    <= '0;
      sweepCount   <= '0;
      timeoutCount <= '0;
      overrunCount <= '0;
    end else begin
      if (state == IDLE && FAstrobe) nReg <= bpmCount;
      if (state == WAIT_VALID && readoutValid) begin
        enTag   <= fofbEnabled;
        nextIdx <= '0;
      end

      // Address moves only on an issue or park: every change commits a slot downstream
      flightValid <= issue;
      if (issue) begin
        fofbDSPreadoutAddress <= nextIdx[FOFB_INDEX_WIDTH-1:0];
        flightIdx             <= nextIdx[FOFB_INDEX_WIDTH-1:0];
        flightLast            <= issueLast;
        nextIdx               <= nextIdx + BPM_COUNT_WIDTH'(1);
      end else if (state == PARK) begin
        fofbDSPreadoutAddress <= nReg[FOFB_INDEX_WIDTH-1:0];
      end

      if (flightValid) begin
        fifoData[wrPtr] <= {fofbDSPreadoutS, fofbDSPreadoutY, fofbDSPreadoutX};
        fifoIdx[wrPtr]  <= flightIdx;
        fifoLast[wrPtr] <= flightLast;
        wrPtr           <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      fifoCount <= fifoCount + 2'(flightValid) - 2'(pop);

      if (sweepDone) sweepCount <= satInc(sweepCount);
      if (state == WAIT_VALID && !readoutValid && sysTimeoutStrobe)
        timeoutCount <= satInc(timeoutCount);
      if (state != IDLE && FAstrobe) overrunCount <= satInc(overrunCount);
    end
  end

endmodule

// File: tb/tb_fofb_dsp_readout_sequencer.sv
// Randomized scoreboard bench for fofb_dsp_readout_sequencer: per-frame beat and
// address expectations are built from slot indices and compared on the falling edge.
module tb_fofb_dsp_readout_sequencer;
  localparam int FIW = 9;
  localparam int BCW = FIW + 1;
  localparam int SW  = 16;

  typedef struct packed {
    logic [95:0]  data;
    logic [FIW:0] user;
    logic         last;
  } beat_t;

  logic           sysClk, sysResetN;
  logic           FAstrobe, readoutValid, sysTimeoutStrobe, fofbEnabled;
  logic [BCW-1:0] bpmCount;
  logic [FIW-1:0] addr;
  logic [31:0]    rdX, rdY, rdS, salt;
  logic           busy;
  logic [SW-1:0]  sweepCount, timeoutCount, overrunCount;

  fofb_dsp_readout_sequencer_if #(.INDEX_WIDTH(FIW)) axis ();

  fofb_dsp_readout_sequencer #(
    .FOFB_INDEX_WIDTH(FIW),
    .BPM_COUNT_WIDTH (BCW),
    .STAT_WIDTH      (SW)
  ) dut (
    .sysClk               (sysClk),
    .sysResetN            (sysResetN),
    .FAstrobe             (FAstrobe),
    .readoutValid         (readoutValid),
    .sysTimeoutStrobe     (sysTimeoutStrobe),
    .fofbEnabled          (fofbEnabled),
    .bpmCount             (bpmCount),
    .fofbDSPreadoutAddress(addr),
    .fofbDSPreadoutX      (rdX),
    .fofbDSPreadoutY      (rdY),
    .fofbDSPreadoutS      (rdS),
    .M_AXIS               (axis.master),
    .busy                 (busy),
    .sweepCount           (sweepCount),
    .timeoutCount         (timeoutCount),
    .overrunCount         (overrunCount)
  );

  int    vecCount = 0;
  int    errCount = 0;
  int    modelSweeps = 0, modelTimeouts = 0, modelOverruns = 0;
  int    modelPark = 0;
  int    rdyMode = 0;
  int    rdyPhase = 0;
  bit    monOff = 1'b0;
  beat_t expQ[$];
  logic [FIW-1:0] addrQ[$];

  // Gather-stage model: readout value is a hash of slot, frame salt and channel
  function automatic logic [31:0] mix(input logic [FIW-1:0] a, input logic [31:0] s,
                                      input logic [1:0] ch);
    return ({23'd0, a} * 32'h9E3779B1) ^ s ^ ({30'd0, ch} * 32'h7F4A7C15);
  endfunction

  assign rdX = mix(addr, salt, 2'd0);
  assign rdY = mix(addr, salt, 2'd1);
  assign rdS = mix(addr, salt, 2'd2);

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  initial begin
    axis.TREADY = 1'b0;
    forever begin
      @(posedge sysClk);
      #1;
      rdyPhase++;
      case (rdyMode)
        0:       axis.TREADY = 1'b1;
        1:       axis.TREADY = (rdyPhase % 4 == 0) || (rdyPhase % 4 == 3);
        2:       axis.TREADY = 1'($urandom_range(0, 1));
        default: axis.TREADY = 1'b0;
      endcase
    end
  end

  logic [107:0] curBeat, savedBeat;
  logic [FIW-1:0] prevAddr;
  bit    prevStall = 1'b0;
  beat_t b;

  initial prevAddr = '0;

  always @(negedge sysClk) begin
    curBeat = {axis.TVALID, axis.TLAST, axis.TUSER, axis.TDATA};
    if (!monOff && sysResetN) begin
      if (addr != prevAddr) begin
        if (addrQ.size() != 0) checkVal("addrSeq", 128'(addr), 128'(addrQ.pop_front()));
        else                   checkVal("addrStray", 128'(addr), 128'(prevAddr));
      end
      if (prevStall) checkVal("holdStable", 128'(curBeat), 128'(savedBeat));
      if (expQ.size() == 0) begin
        checkVal("idleValid", 128'(axis.TVALID), 128'(0));
      end else if (axis.TVALID && axis.TREADY) begin
        b = expQ.pop_front();
        checkVal("beatData", 128'(axis.TDATA), 128'(b.data));
        checkVal("beatUser", 128'(axis.TUSER), 128'(b.user));
        checkVal("beatLast", 128'(axis.TLAST), 128'(b.last));
      end
    end
    prevAddr  = addr;
    prevStall = axis.TVALID && !axis.TREADY;
    savedBeat = curBeat;
  end

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic checkCounters(input string tag);
    checkVal({tag, ".sweeps"},   128'(sweepCount),   128'(modelSweeps));
    checkVal({tag, ".timeouts"}, 128'(timeoutCount), 128'(modelTimeouts));
    checkVal({tag, ".overruns"}, 128'(overrunCount), 128'(modelOverruns));
  endtask

  task automatic runFrame(input int n, input bit en, input int delay, input int mode,
                          input bit withTo, input bit midStrobe);
    int k;
    beat_t e;
    logic [FIW-1:0] a;
    rdyMode  = mode;
    salt     = $urandom;
    bpmCount = BCW'(n);
    for (int i = 0; i < n; i++) begin
      e.data = {mix(FIW'(i), salt, 2'd2), mix(FIW'(i), salt, 2'd1), mix(FIW'(i), salt, 2'd0)};
      e.user = {en, FIW'(i)};
      e.last = (i == n - 1);
      expQ.push_back(e);
      a = FIW'(i);
      if (!(i == 0 && int'(a) == modelPark)) addrQ.push_back(a);
    end
    addrQ.push_back(FIW'(n % (1 << FIW)));
    tick();
    FAstrobe = 1'b1;
    tick();
    FAstrobe = 1'b0;
    repeat (delay - 1) tick();
    fofbEnabled      = en;
    readoutValid     = 1'b1;
    sysTimeoutStrobe = withTo;
    tick();
    readoutValid     = 1'b0;
    sysTimeoutStrobe = 1'b0;
    k = 0;
    while (k < 3000) begin
      @(negedge sysClk);
      if (!busy) break;
      k++;
      if (midStrobe) begin
        if (k == 3) begin FAstrobe = 1'b1; sysTimeoutStrobe = 1'b1; end
        if (k == 4) begin FAstrobe = 1'b0; sysTimeoutStrobe = 1'b0; end
        if (k == 20) rdyMode = 0;
      end
    end
    checkVal("sweepDone", 128'(busy), 128'(0));
    if (mode == 0) checkVal("sweepCycles", 128'(k), 128'(n + 2));
    checkVal("beatsLeft", 128'(expQ.size()), 128'(0));
    modelSweeps++;
    if (midStrobe) modelOverruns++;
    modelPark = n % (1 << FIW);
    checkCounters("frame");
  endtask

  initial begin
    int k;
    sysResetN = 1'b0;
    FAstrobe = 1'b0; readoutValid = 1'b0; sysTimeoutStrobe = 1'b0;
    fofbEnabled = 1'b0; bpmCount = '0; salt = 32'h1234_5678;
    repeat (3) @(posedge sysClk);
    @(negedge sysClk);
    checkVal("rst.tvalid", 128'(axis.TVALID), 128'(0));
    checkVal("rst.tlast",  128'(axis.TLAST),  128'(0));
    checkVal("rst.tdata",  128'(axis.TDATA),  128'(0));
    checkVal("rst.tuser",  128'(axis.TUSER),  128'(0));
    checkVal("rst.busy",   128'(busy),        128'(0));
    checkVal("rst.addr",   128'(addr),        128'(0));
    checkCounters("rst");
    sysResetN = 1'b1;

    runFrame(4, 1'b1, 3, 0, 1'b1, 1'b0);
    runFrame(8, 1'b0, 2, 1, 1'b0, 1'b0);

    tick();
    FAstrobe = 1'b1;
    tick();
    FAstrobe = 1'b0;
    tick();
    sysTimeoutStrobe = 1'b1;
    tick();
    sysTimeoutStrobe = 1'b0;
    @(negedge sysClk);
    checkVal("timeoutBusy", 128'(busy), 128'(0));
    modelTimeouts++;
    checkCounters("timeout");

    runFrame(4, 1'b1, 1, 3, 1'b0, 1'b1);
    tick();
    readoutValid = 1'b1;
    tick();
    readoutValid = 1'b0;
    @(negedge sysClk);
    checkVal("noSecondSweep", 128'(busy), 128'(0));

    bpmCount = '0;
    tick();
    FAstrobe = 1'b1;
    tick();
    FAstrobe = 1'b0;
    readoutValid = 1'b1;
    tick();
    readoutValid = 1'b0;
    repeat (3) begin
      @(negedge sysClk);
      checkVal("zeroBusy", 128'(busy), 128'(0));
    end
    checkCounters("zero");

    runFrame(1 << FIW, 1'b1, 2, 0, 1'b0, 1'b0);

    monOff = 1'b1;
    rdyMode = 0;
    bpmCount = BCW'(10);
    tick();
    FAstrobe = 1'b1;
    tick();
    FAstrobe = 1'b0;
    readoutValid = 1'b1;
    tick();
    readoutValid = 1'b0;
    k = 0;
    do begin
      @(negedge sysClk);
      k++;
    end while (addr != FIW'(5) && k < 50);
    checkVal("reachIdx5", 128'(addr), 128'(5));
    #2 sysResetN = 1'b0;
    #1;
    checkVal("midRst.tvalid", 128'(axis.TVALID), 128'(0));
    checkVal("midRst.addr",   128'(addr),        128'(0));
    checkVal("midRst.busy",   128'(busy),        128'(0));
    @(negedge sysClk);
    #2 sysResetN = 1'b1;
    modelSweeps = 0; modelTimeouts = 0; modelOverruns = 0; modelPark = 0;
    @(negedge sysClk);
    monOff = 1'b0;
    runFrame(6, 1'b1, 2, 0, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++)
      runFrame(int'($urandom_range(1, 16)), 1'($urandom_range(0, 1)),
               int'($urandom_range(1, 4)), int'($urandom_range(1, 2)),
               1'($urandom_range(0, 1)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
